// File: rtl/uart_packet_ctrl_pkg.sv
// Shared types and constants for the UART packet controller and its byte shifter.
package uart_packet_ctrl_pkg;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_STROBE = 2'd1,
    TX_GAP    = 2'd2
  } tx_state_e;

  localparam int DEF_BAUD_VAL  = 26;
  localparam int DEF_BAUD_FRAC = 1;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uart_byte_shifter.sv
// Byte-wide shift register with parallel load; MSB_FIRST picks the shift direction
// so the same block assembles RX bytes and serialises TX words.
module uart_byte_shifter
  import uart_packet_ctrl_pkg::*;
#(
  parameter int BYTES     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               load,
  input  logic [8*BYTES-1:0] load_data,
  input  logic               shift,
  input  logic [7:0]         shift_in,
  output logic [8*BYTES-1:0] data
);

  localparam int W = 8 * BYTES;

  logic [W+7:0] ext;
  logic [W-1:0] shifted;

  // Left shift feeds the new byte at the bottom; right shift feeds it at the top.
  always_comb begin
    ext     = MSB_FIRST ? {data, shift_in} : {shift_in, data};
    shifted = MSB_FIRST ? ext[W-1:0] : ext[W+7:8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   data <= '0;
    else if (clr)   data <= '0;
    else if (load)  data <= load_data;
    else if (shift) data <= shifted;
  end

endmodule

// File: rtl/uart_packet_ctrl.sv
// Packet controller between a CoreUART byte interface and a processing core:
// assembles RX bytes into packets with start hold-off, and serialises core results.
module uart_packet_ctrl
  import uart_packet_ctrl_pkg::*;
#(
  parameter int RX_BYTES   = 4,
  parameter int TX_BYTES   = 1,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int OEN_WAIT   = 3,
  parameter int RX_TIMEOUT = 1000000,
  parameter int BAUD_VAL   = DEF_BAUD_VAL,
  parameter int BAUD_FRAC  = DEF_BAUD_FRAC
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rxrdy,
  input  logic [7:0]            rx_data,
  output logic                  oen,
  input  logic                  txrdy,
  output logic [7:0]            tx_data,
  output logic                  wen,
  output logic [12:0]           baud_val,
  output logic [2:0]            baud_val_frac,
  output logic [8*RX_BYTES-1:0] pkt_data,
  output logic                  pkt_valid,
  input  logic                  core_ready,
  input  logic                  core_finish,
  input  logic [8*TX_BYTES-1:0] core_result,
  output logic                  tx_busy,
  output logic                  rx_timeout,
  output logic                  overrun
);

  localparam int RX_W   = 8 * RX_BYTES;
  localparam int TX_W   = 8 * TX_BYTES;
  localparam int RXC_W  = cnt_w(RX_BYTES);
  localparam int TXC_W  = cnt_w(TX_BYTES);
  localparam int OEN_W  = cnt_w(OEN_WAIT);
  localparam int IDLE_W = cnt_w(RX_TIMEOUT);

  assign baud_val      = 13'(BAUD_VAL);
  assign baud_val_frac = 3'(BAUD_FRAC);

  logic              accept, rx_last, rx_expire, pkt_done_p1, pending;
  logic [OEN_W-1:0]  oen_cnt;
  logic [RXC_W-1:0]  byte_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [RX_W-1:0]   rx_word;
  logic              ovr_rx_set, ovr_tx_set;

  assign oen        = (oen_cnt == '0);
  assign accept     = rxrdy && oen;
  assign rx_last    = accept && (byte_cnt == RXC_W'(RX_BYTES - 1));
  assign rx_expire  = (RX_TIMEOUT != 0) && !accept && (byte_cnt != '0) &&
                      (idle_cnt == IDLE_W'(RX_TIMEOUT - 1));
  assign pkt_valid  = pending && core_ready;
  assign ovr_rx_set = pkt_done_p1 && pending && !core_ready;

  uart_byte_shifter #(.BYTES(RX_BYTES), .MSB_FIRST(MSB_FIRST)) u_rx_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (rx_expire),
    .load      (1'b0),
    .load_data ('0),
    .shift     (accept),
    .shift_in  (rx_data),
    .data      (rx_word)
  );

  // RX byte acceptance, read-strobe hold-off and partial-packet timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oen_cnt     <= '0;
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      pkt_done_p1 <= 1'b0;
      rx_timeout  <= 1'b0;
    end else begin
      rx_timeout  <= rx_expire;
      pkt_done_p1 <= rx_last;
      if (accept)              oen_cnt <= OEN_W'(OEN_WAIT);
      else if (oen_cnt != '0)  oen_cnt <= oen_cnt - OEN_W'(1);
      if (rx_last || rx_expire) byte_cnt <= '0;
      else if (accept)          byte_cnt <= byte_cnt + RXC_W'(1);
      if (accept || rx_expire || byte_cnt == '0 || RX_TIMEOUT == 0) idle_cnt <= '0;
      else                                                          idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // Packet capture, pending hold-off and sticky overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_data <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (pkt_done_p1) begin
        pkt_data <= rx_word;
        pending  <= 1'b1;
      end else if (pkt_valid) begin
        pending  <= 1'b0;
      end
      if (ovr_rx_set || ovr_tx_set) overrun <= 1'b1;
    end
  end

  tx_state_e        state, state_nxt;
  logic [TXC_W-1:0] tx_left;
  logic [TX_W-1:0]  tx_word;
  logic [7:0]       tx_byte, tx_data_q;
  logic             tx_load, tx_strobe;

  assign tx_byte    = MSB_FIRST ? tx_word[TX_W-1 -: 8] : tx_word[7:0];
  assign tx_busy    = (state != TX_IDLE);
  assign ovr_tx_set = core_finish && (state != TX_IDLE);

  uart_byte_shifter #(.BYTES(TX_BYTES), .MSB_FIRST(MSB_FIRST)) u_tx_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (1'b0),
    .load      (tx_load),
    .load_data (core_result),
    .shift     (tx_strobe),
    .shift_in  (8'h00),
    .data      (tx_word)
  );

  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    tx_strobe = 1'b0;
    wen       = 1'b1;
    tx_data   = tx_data_q;
    case (state)
      TX_IDLE: begin
        if (core_finish) begin
          tx_load   = 1'b1;
          state_nxt = TX_STROBE;
        end
      end
      TX_STROBE: begin
        if (txrdy) begin
          tx_strobe = 1'b1;
          wen       = 1'b0;
          tx_data   = tx_byte;
          state_nxt = TX_GAP;
        end
      end
      TX_GAP:  state_nxt = (tx_left != '0) ? TX_STROBE : TX_IDLE;
      default: state_nxt = TX_IDLE;
    endcase
  end

  // TX sequencer state, remaining-byte count and held output byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= TX_IDLE;
      tx_left   <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state <= state_nxt;
      if (tx_load)        tx_left <= TXC_W'(TX_BYTES);
      else if (tx_strobe) tx_left <= tx_left - TXC_W'(1);
      if (tx_strobe) tx_data_q <= tx_byte;
    end
  end

endmodule

// File: tb/tb_uart_packet_ctrl.sv
// Scoreboard bench: an MSB-first and an LSB-first controller share all inputs;
// expected packets and TX bytes are queued at stimulus time and popped on output.
module tb_uart_packet_ctrl;

  localparam int RXB = 4;
  localparam int TXB = 2;
  localparam int TMO = 50;

  logic clk = 1'b0, reset_n = 1'b0;
  logic rxrdy = 1'b0, txrdy = 1'b0, core_ready = 1'b0, core_finish = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [8*TXB-1:0] core_result = '0;

  logic oen, wen, pkt_valid, tx_busy, rx_timeout, overrun;
  logic [7:0] tx_data;
  logic [12:0] baud_val;
  logic [2:0] baud_val_frac;
  logic [8*RXB-1:0] pkt_data;

  logic oen_l, wen_l, pkt_valid_l, tx_busy_l, rx_timeout_l, overrun_l;
  logic [7:0] tx_data_l;
  logic [12:0] baud_val_l;
  logic [2:0] baud_val_frac_l;
  logic [8*RXB-1:0] pkt_data_l;

  int tests = 0, failed = 0, cyc = 0, pv_count = 0, wen_count = 0;
  logic wen_prev_low = 1'b0;
  logic [8*RXB-1:0] pkt_q[$], pkt_ql[$];
  logic [7:0] tx_q[$], tx_ql[$];

  uart_packet_ctrl #(.RX_BYTES(RXB), .TX_BYTES(TXB), .MSB_FIRST(1'b1), .OEN_WAIT(3),
                     .RX_TIMEOUT(TMO)) u_dut (
    .clk(clk), .reset_n(reset_n), .rxrdy(rxrdy), .rx_data(rx_data), .oen(oen),
    .txrdy(txrdy), .tx_data(tx_data), .wen(wen), .baud_val(baud_val),
    .baud_val_frac(baud_val_frac), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
    .core_ready(core_ready), .core_finish(core_finish), .core_result(core_result),
    .tx_busy(tx_busy), .rx_timeout(rx_timeout), .overrun(overrun)
  );

  uart_packet_ctrl #(.RX_BYTES(RXB), .TX_BYTES(TXB), .MSB_FIRST(1'b0), .OEN_WAIT(3),
                     .RX_TIMEOUT(TMO)) u_lsb (
    .clk(clk), .reset_n(reset_n), .rxrdy(rxrdy), .rx_data(rx_data), .oen(oen_l),
    .txrdy(txrdy), .tx_data(tx_data_l), .wen(wen_l), .baud_val(baud_val_l),
    .baud_val_frac(baud_val_frac_l), .pkt_data(pkt_data_l), .pkt_valid(pkt_valid_l),
    .core_ready(core_ready), .core_finish(core_finish), .core_result(core_result),
    .tx_busy(tx_busy_l), .rx_timeout(rx_timeout_l), .overrun(overrun_l)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard whenever a packet start or a TX strobe appears.
  always @(negedge clk) begin
    if (reset_n) begin
      if (pkt_valid) begin
        pv_count++;
        chk("pkt_expected", pkt_q.size() > 0, 1);
        if (pkt_q.size() > 0) begin
          chk("pkt_data", pkt_data, pkt_q.pop_front());
          chk("pkt_data_lsb", pkt_data_l, pkt_ql.pop_front());
        end
        chk("pkt_valid_lsb", pkt_valid_l, 1);
      end
      if (!wen) begin
        wen_count++;
        chk("wen_gap", wen_prev_low, 0);
        chk("tx_expected", tx_q.size() > 0, 1);
        if (tx_q.size() > 0) begin
          chk("tx_data", tx_data, tx_q.pop_front());
          chk("tx_data_lsb", tx_data_l, tx_ql.pop_front());
        end
        chk("wen_lsb", wen_l, 0);
      end
      wen_prev_low = !wen;
    end
  end

  task automatic check_reset(input string ph);
    chk({ph, "_oen"}, oen, 1);
    chk({ph, "_wen"}, wen, 1);
    chk({ph, "_tx_data"}, tx_data, 0);
    chk({ph, "_pkt_data"}, pkt_data, 0);
    chk({ph, "_pkt_valid"}, pkt_valid, 0);
    chk({ph, "_tx_busy"}, tx_busy, 0);
    chk({ph, "_rx_timeout"}, rx_timeout, 0);
    chk({ph, "_overrun"}, overrun, 0);
    chk({ph, "_overrun_lsb"}, overrun_l, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc, output logic [3:0] pv);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!oen && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("oen_ready", oen, 1);
    rx_data = b;
    rxrdy   = 1'b1;
    @(posedge clk); #1;
    acc   = cyc;
    rxrdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pv[i] = pkt_valid;
      chk("oen_hold", oen, (i < 3) ? 1'b0 : 1'b1);
    end
  endtask

  task automatic send_pkt(input logic [31:0] w, input bit expect_it, output logic [3:0] pv_last);
    int acc;
    logic [3:0] pv;
    if (expect_it) begin
      pkt_q.push_back(w);
      pkt_ql.push_back({w[7:0], w[15:8], w[23:16], w[31:24]});
    end
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], acc, pv);
    pv_last = pv;
  endtask

  task automatic push_tx(input logic [15:0] r);
    tx_q.push_back(r[15:8]);
    tx_q.push_back(r[7:0]);
    tx_ql.push_back(r[7:0]);
    tx_ql.push_back(r[15:8]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, n;
    logic [3:0] pv;

    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    chk("baud_val", baud_val, 26);
    chk("baud_val_frac", baud_val_frac, 1);
    reset_n = 1'b1;

    // Basic packet with core ready
    core_ready = 1'b1;
    send_pkt(32'h11223344, 1'b1, pv);
    chk("pkt_valid_timing", pv, 4'b0010);
    chk("pkt_valid_count1", pv_count, 1);
    chk("overrun_clean", overrun, 0);

    // Partial packet timeout, then a fresh packet
    send_byte(8'hDE, acc, pv);
    send_byte(8'hAD, acc, pv);
    n = 0;
    while (!rx_timeout && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rx_timeout_delay", cyc - acc, TMO);
    chk("rx_timeout_lsb", rx_timeout_l, 1);
    @(negedge clk);
    chk("rx_timeout_pulse", rx_timeout, 0);
    chk("pkt_data_kept", pkt_data, 32'h11223344);
    send_pkt(32'hCAFE0BAD, 1'b1, pv);
    chk("pkt_after_timeout_timing", pv, 4'b0010);
    chk("pkt_valid_count2", pv_count, 2);

    // Two-byte TX with txrdy toggling and a late core_finish
    @(posedge clk); #1;
    push_tx(16'hA55A);
    for (int i = 0; i < 16; i++) begin
      txrdy       = (i % 3 != 1);
      core_finish = (i == 0 || i == 6);
      core_result = (i == 0) ? 16'hA55A : 16'h1234;
      if (i == 3) chk("tx_busy", tx_busy, 1);
      if (i == 6) chk("overrun_pre_tx", overrun, 0);
      @(posedge clk); #1;
    end
    core_finish = 1'b0;
    txrdy       = 1'b0;
    chk("tx_strobes", wen_count, 2);
    chk("tx_busy_done", tx_busy, 0);
    chk("tx_data_hold", tx_data, 8'h5A);
    chk("tx_data_hold_lsb", tx_data_l, 8'hA5);
    chk("overrun_tx", overrun, 1);
    chk("overrun_tx_lsb", overrun_l, 1);
    chk("tx_q_empty", tx_q.size(), 0);

    // Asynchronous reset mid-packet and mid-TX
    send_byte(8'h77, acc, pv);
    @(posedge clk); #1;
    core_result = 16'hBEEF;
    core_finish = 1'b1;
    rx_data     = 8'h88;
    rxrdy       = 1'b1;
    @(posedge clk); #1;
    core_finish = 1'b0;
    rxrdy       = 1'b0;
    chk("tx_busy_pre_rst", tx_busy, 1);
    chk("oen_pre_rst", oen, 0);
    #2 reset_n = 1'b0;
    #1 check_reset("async_rst");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Clean packet and TX after reset
    send_pkt(32'h0102A0B0, 1'b1, pv);
    chk("pkt_post_rst_timing", pv, 4'b0010);
    @(posedge clk); #1;
    push_tx(16'h3CC3);
    core_result = 16'h3CC3;
    core_finish = 1'b1;
    txrdy       = 1'b1;
    @(posedge clk); #1;
    core_finish = 1'b0;
    n = 0;
    while (tx_busy && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    txrdy = 1'b0;
    chk("tx_post_rst_done", tx_busy, 0);
    chk("tx_post_rst_strobes", wen_count, 4);

    // Start hold-off while the core is busy
    core_ready = 1'b0;
    send_pkt(32'h55AA1234, 1'b1, pv);
    repeat (20) @(posedge clk);
    #1;
    chk("holdoff_no_valid", pv_count, 3);
    core_ready = 1'b1;
    @(negedge clk);
    chk("holdoff_valid", pkt_valid, 1);
    @(posedge clk); #1;
    chk("holdoff_count", pv_count, 4);

    // Second packet lands while the first is still pending
    core_ready = 1'b0;
    send_pkt(32'h01020304, 1'b0, pv);
    chk("overrun_pre_rx", overrun, 0);
    send_pkt(32'hF0E0D0C0, 1'b1, pv);
    chk("overrun_rx", overrun, 1);
    chk("overrun_rx_lsb", overrun_l, 1);
    chk("pkt_data_second", pkt_data, 32'hF0E0D0C0);
    @(posedge clk); #1;
    core_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pv_count_final", pv_count, 5);
    chk("pkt_q_empty", pkt_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
